// File: rtl/fpu_f2i_pkg.sv
// Shared types and constants for the half-precision to 32-bit integer converter.
package fpu_f2i_pkg;

    // Half-precision field layout
    localparam int unsigned STD  = 15;  // float width minus 1
    localparam int unsigned MAN  = 9;   // stored mantissa MSB index
    localparam int unsigned EXP  = 4;   // exponent field MSB index
    localparam int unsigned BIAS = 15;  // exponent bias

    // Rounding modes; encodings 101-111 fall through to truncation
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // Saturation results for invalid conversions
    localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle,
        StAlign,
        StRound,
        StDone
    } f2i_state_e;

endpackage

// File: rtl/fpu_f2i_align.sv
// Combinational alignment of the half-precision significand to an integer
// magnitude with guard, round and sticky bits.
module fpu_f2i_align
    import fpu_f2i_pkg::*;
(
    input  logic              [MAN+1:0] sig,
    input  logic signed       [5:0]     e,
    output logic              [31:0]    mag,
    output logic                        g,
    output logic                        r,
    output logic                        s
);

    logic [5:0]  lsh;
    logic [5:0]  rsh;
    logic [22:0] ext;

    // Left shift for integral values, capped right shift otherwise; the 12 zero
    // bits below the significand hold every shifted-out bit when rsh <= 12.
    always_comb begin
        mag = '0;
        g   = 1'b0;
        r   = 1'b0;
        s   = 1'b0;
        ext = '0;
        lsh = 6'(e - 6'sd10);
        rsh = 6'(6'sd10 - e);
        if (e >= 6'sd10) begin
            mag = {21'b0, sig} << lsh;
        end else begin
            if (rsh > 6'd12) begin
                rsh = 6'd12;
            end
            ext = {sig, 12'b0} >> rsh;
            mag = {21'b0, ext[22:12]};
            g   = ext[11];
            r   = ext[10];
            s   = |ext[9:0];
        end
    end

endmodule

// File: rtl/fpu_float_to_int_seq.sv
// Multi-cycle half-precision to 32-bit signed/unsigned integer converter
// (FCVT.W.H / FCVT.WU.H) with valid/ready handshakes on both sides.
// Optional accrued flags are enabled by defining FPU_F2I_ACCRUED_FLAGS_EN.
module fpu_float_to_int_seq
    import fpu_f2i_pkg::*;
(
    input  logic         clk,
    input  logic         rst_l,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [STD:0] in_float,
    input  logic [2:0]   in_rm,
    input  logic         in_signed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_int,
    output logic         out_invalid,
    output logic         out_inexact,
    output logic         acc_invalid,
    output logic         acc_inexact,
    input  logic         acc_clear
);

    f2i_state_e state_q, state_d;

    logic [STD:0]      op_q;
    logic [2:0]        rm_q;
    logic              sgn_q;
    logic [31:0]       mag_q;
    logic              g_q, r_q, s_q;
    logic [31:0]       int_q;
    logic              nv_q, nx_q;

    logic [EXP:0]      exp_f;
    logic [MAN:0]      man_f;
    logic              neg;
    logic [MAN+1:0]    sig;
    logic signed [5:0] e;
    logic [31:0]       al_mag;
    logic              al_g, al_r, al_s;

    logic              inc;
    logic              nx_raw;
    logic [31:0]       rounded;
    logic [31:0]       res_int;
    logic              res_nv, res_nx;

    assign exp_f = op_q[STD-1:MAN+1];
    assign man_f = op_q[MAN:0];
    assign neg   = op_q[STD];
    // Hidden bit is clear for zero and subnormals
    assign sig   = {|exp_f, man_f};
    assign e     = {1'b0, exp_f} - 6'(BIAS);

    fpu_f2i_align u_align (
        .sig (sig),
        .e   (e),
        .mag (al_mag),
        .g   (al_g),
        .r   (al_r),
        .s   (al_s)
    );

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StAlign;
            end
            StAlign: state_d = StRound;
            StRound: state_d = StDone;
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Rounding, sign application and special-case results
    always_comb begin
        nx_raw = g_q | r_q | s_q;
        case (rm_q)
            RM_RNE:  inc = g_q & (r_q | s_q | mag_q[0]);
            RM_RDN:  inc = neg & nx_raw;
            RM_RUP:  inc = ~neg & nx_raw;
            RM_RMM:  inc = g_q;
            default: inc = 1'b0;
        endcase
        rounded = mag_q + 32'(inc);
        res_int = '0;
        res_nv  = 1'b0;
        res_nx  = 1'b0;
        if (&exp_f) begin
            res_nv = 1'b1;
            if ((|man_f) || !neg) begin
                res_int = sgn_q ? INT_MAX : UINT_MAX;
            end else begin
                res_int = sgn_q ? INT_MIN : '0;
            end
        end else if (neg && !sgn_q) begin
            // Negative to unsigned: invalid unless it rounds to zero
            if (rounded != '0) begin
                res_nv = 1'b1;
            end else begin
                res_nx = nx_raw;
            end
        end else begin
            res_int = neg ? (~rounded + 32'd1) : rounded;
            res_nx  = nx_raw;
        end
    end

    // Datapath registers: operand capture, alignment, result
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            op_q  <= '0;
            rm_q  <= '0;
            sgn_q <= 1'b0;
            mag_q <= '0;
            g_q   <= 1'b0;
            r_q   <= 1'b0;
            s_q   <= 1'b0;
            int_q <= '0;
            nv_q  <= 1'b0;
            nx_q  <= 1'b0;
        end else begin
            if (state_q == StIdle && in_valid) begin
                op_q  <= in_float;
                rm_q  <= in_rm;
                sgn_q <= in_signed;
            end
            if (state_q == StAlign) begin
                mag_q <= al_mag;
                g_q   <= al_g;
                r_q   <= al_r;
                s_q   <= al_s;
            end
            if (state_q == StRound) begin
                int_q <= res_int;
                nv_q  <= res_nv;
                nx_q  <= res_nx;
            end
        end
    end

    assign out_int     = int_q;
    assign out_invalid = nv_q;
    assign out_inexact = nx_q;

`ifdef FPU_F2I_ACCRUED_FLAGS_EN
    // Sticky flags accumulated on each output handshake; clear wins
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            acc_invalid <= 1'b0;
            acc_inexact <= 1'b0;
        end else if (acc_clear) begin
            acc_invalid <= 1'b0;
            acc_inexact <= 1'b0;
        end else if (out_valid && out_ready) begin
            acc_invalid <= acc_invalid | nv_q;
            acc_inexact <= acc_inexact | nx_q;
        end
    end
`else
    logic unused_acc_clear;
    assign unused_acc_clear = acc_clear;
    assign acc_invalid      = 1'b0;
    assign acc_inexact      = 1'b0;
`endif

endmodule
